// File: rtl/data_read_pkg.sv
// rtl/data_read_pkg.sv - shared types and constants for the data_read AXI4-Lite read slave
//
// Purpose: FSM state enum, decode kinds, RRESP codes, register word offsets,
//          region field width and the buffer-select width helper.
// Ports:   none (package).

package data_read_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Outcome of decoding one read address.
  typedef enum logic [1:0] {
    KIND_REG = 2'd0,
    KIND_BUF = 2'd1,
    KIND_ERR = 2'd2
  } kind_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_CR     = 2'd0;
  localparam logic [1:0] REG_SR     = 2'd1;
  localparam logic [1:0] REG_ERRCNT = 2'd2;

  localparam int REGION_W = 4;

  // max(1, clog2(n)): a single buffer still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_read_axi_rd_mc_if.sv
// rtl/data_read_axi_rd_mc_if.sv - AXI4-Lite read address/data channel bundle
//
// Purpose: groups the AR and R channel signals of the data_read read slave.
// Ports:   araddr/arvalid/arready (address channel),
//          rdata/rresp/rvalid/rready (data channel).
//          modport slave  - used by data_read_axi_rd_mc
//          modport master - used by the interconnect side

interface data_read_axi_rd_mc_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  araddr,
    input  arvalid,
    output arready,
    output rdata,
    output rresp,
    output rvalid,
    input  rready
  );

  modport master (
    output araddr,
    output arvalid,
    input  arready,
    input  rdata,
    input  rresp,
    input  rvalid,
    output rready
  );

endinterface

// File: rtl/data_read_addr_dec.sv
// rtl/data_read_addr_dec.sv - combinational read address decoder
//
// Purpose: splits a byte address into region and word, and classifies it as
//          a register read, a buffer read or an unmapped (error) access.
// Ports:   addr    in  ADDR_W  byte address being accepted
//          kind    out kind_t  KIND_REG / KIND_BUF / KIND_ERR
//          sel     out SEL_W   buffer index (region - 1)
//          word    out BUF_AW  word address within region
//          reg_idx out 2       register offset within region 0

module data_read_addr_dec
  import data_read_pkg::*;
#(
  parameter int NUM_BUF = 4,
  parameter int BUF_AW  = 10,
  parameter int ADDR_W  = 32,
  parameter int SEL_W   = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output kind_t             kind,
  output logic [SEL_W-1:0]  sel,
  output logic [BUF_AW-1:0] word,
  output logic [1:0]        reg_idx
);

  logic [REGION_W-1:0] region;
  logic [REGION_W-1:0] region_m1;

  assign word      = addr[BUF_AW+1:2];
  assign region    = addr[BUF_AW+5:BUF_AW+2];
  assign region_m1 = region - REGION_W'(1);
  assign sel       = region_m1[SEL_W-1:0];
  assign reg_idx   = word[1:0];

  always_comb begin
    kind = KIND_ERR;
    if (region == '0) begin
      // Only words 0..2 are implemented in the register region.
      if ((word[BUF_AW-1:2] == '0) && (word[1:0] != 2'd3)) begin
        kind = KIND_REG;
      end
    end else if (region <= REGION_W'(NUM_BUF)) begin
      kind = KIND_BUF;
    end
  end

  // Byte-lane bits and address bits above the region field do not take part
  // in the decode.
  logic unused_lo;
  assign unused_lo = ^addr[1:0];

  generate
    if (ADDR_W > BUF_AW + 6) begin : g_upper
      logic unused_hi;
      assign unused_hi = ^addr[ADDR_W-1:BUF_AW+6];
    end
  endgenerate

endmodule

// File: rtl/data_read_axi_rd_mc.sv
// rtl/data_read_axi_rd_mc.sv - AXI4-Lite read slave for data_read registers and capture buffers
//
// Purpose: serves CR/SR/ERRCNT in region 0 and NUM_BUF buffer RAMs in regions
//          1..NUM_BUF with one outstanding read; unmapped reads get SLVERR.
//          Optional macro DATA_READ_AXI_ERRCNT_EN adds a 16-bit saturating,
//          clear-on-read count of SLVERR responses at region 0 word 2.
// Ports:   S_AXI_ACLK   in   clock, rising edge
//          S_AXI_ARESET in   synchronous active-high reset
//          s_axi        slave AR/R channel (araddr, arvalid, arready,
//                             rdata, rresp, rvalid, rready)
//          sr_c         in   NUM_BUF per-buffer capture-complete flags
//          buf_en       out  buffer read strobe
//          buf_addr     out  buffer word address
//          buf_sel      out  buffer index, 0-based
//          buf_data     in   selected buffer data

module data_read_axi_rd_mc
  import data_read_pkg::*;
#(
  parameter int  NUM_BUF = 4,
  parameter int  BUF_AW  = 10,
  parameter int  BUF_LAT = 1,
  parameter int  ADDR_W  = 32,
  localparam int SEL_W   = sel_width(NUM_BUF)
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  data_read_axi_rd_mc_if.slave s_axi,
  input  logic [NUM_BUF-1:0]   sr_c,
  output logic                 buf_en,
  output logic [BUF_AW-1:0]    buf_addr,
  output logic [SEL_W-1:0]     buf_sel,
  input  logic [31:0]          buf_data
);

  localparam logic [1:0] LAT_LAST = 2'(BUF_LAT - 1);

  state_t            state_q, state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              buf_en_q, buf_en_d;
  logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
  logic [SEL_W-1:0]  buf_sel_q, buf_sel_d;
  logic [1:0]        cnt_q, cnt_d;

  kind_t             dec_kind;
  logic [SEL_W-1:0]  dec_sel;
  logic [BUF_AW-1:0] dec_word;
  logic [1:0]        dec_reg;
  logic [31:0]       reg_rdata;
  logic              ar_hs;

  // Decode the address as it is accepted so every output can be registered
  // directly at the handshake edge.
  data_read_addr_dec #(
    .NUM_BUF (NUM_BUF),
    .BUF_AW  (BUF_AW),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W)
  ) u_addr_dec (
    .addr    (s_axi.araddr),
    .kind    (dec_kind),
    .sel     (dec_sel),
    .word    (dec_word),
    .reg_idx (dec_reg)
  );

  assign ar_hs = (state_q == IDLE) && s_axi.arvalid && arready_q;

`ifdef DATA_READ_AXI_ERRCNT_EN
  logic [15:0] errcnt_q;
  logic        errcnt_clr_q;
  logic        rd_beat;

  assign rd_beat = (state_q == RESP) && s_axi.rready;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      errcnt_q     <= '0;
      errcnt_clr_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        errcnt_clr_q <= (dec_kind == KIND_REG) && (dec_reg == REG_ERRCNT);
      end
      if (rd_beat) begin
        // Clear-on-read wins over any increment landing on the same beat.
        if (errcnt_clr_q) begin
          errcnt_q <= '0;
        end else if ((rresp_q == RESP_SLVERR) && (errcnt_q != 16'hFFFF)) begin
          errcnt_q <= errcnt_q + 16'd1;
        end
      end
    end
  end
`endif

  always_comb begin
    reg_rdata = '0;
    case (dec_reg)
      REG_SR:     reg_rdata = 32'(sr_c);
`ifdef DATA_READ_AXI_ERRCNT_EN
      REG_ERRCNT: reg_rdata = {16'd0, errcnt_q};
`endif
      default:    reg_rdata = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    buf_en_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_sel_d  = buf_sel_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          case (dec_kind)
            KIND_BUF: begin
              state_d    = WAIT;
              buf_en_d   = 1'b1;
              buf_addr_d = dec_word;
              buf_sel_d  = dec_sel;
              cnt_d      = '0;
            end
            KIND_REG: begin
              state_d  = RESP;
              rvalid_d = 1'b1;
              rdata_d  = reg_rdata;
              rresp_d  = RESP_OKAY;
            end
            default: begin
              state_d  = RESP;
              rvalid_d = 1'b1;
              rdata_d  = '0;
              rresp_d  = RESP_SLVERR;
            end
          endcase
        end
      end

      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = buf_data;
          rresp_d  = RESP_OKAY;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      RESP: begin
        if (s_axi.rready) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      buf_en_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_sel_q  <= '0;
      cnt_q      <= '0;
    end else begin
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      buf_en_q   <= buf_en_d;
      buf_addr_q <= buf_addr_d;
      buf_sel_q  <= buf_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign buf_en        = buf_en_q;
  assign buf_addr      = buf_addr_q;
  assign buf_sel       = buf_sel_q;

endmodule

// File: tb/tb_data_read_axi_rd_mc.sv
// tb/tb_data_read_axi_rd_mc.sv - directed self-checking bench for data_read_axi_rd_mc

module tb_data_read_axi_rd_mc;

  localparam int NUM_BUF = 4;
  localparam int BUF_AW  = 10;
  localparam int BUF_LAT = 3;
  localparam int ADDR_W  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sr_c = '0;
  logic        buf_en;
  logic [9:0]  buf_addr;
  logic [1:0]  buf_sel;
  logic [31:0] buf_data;
  logic [3:0]  age = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  data_read_axi_rd_mc_if #(.ADDR_W(ADDR_W)) ax ();

  data_read_axi_rd_mc #(
    .NUM_BUF (NUM_BUF),
    .BUF_AW  (BUF_AW),
    .BUF_LAT (BUF_LAT),
    .ADDR_W  (ADDR_W)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (ax.slave),
    .sr_c         (sr_c),
    .buf_en       (buf_en),
    .buf_addr     (buf_addr),
    .buf_sel      (buf_sel),
    .buf_data     (buf_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer RAM model: data is only valid in the last cycle the slave waits.
  always @(posedge clk) begin
    if (rst) age <= '0;
    else if (buf_en) age <= 4'd1;
    else if (age != 4'd0 && age != 4'd15) age <= age + 4'd1;
  end

  function automatic logic [31:0] mem_word(input logic [1:0] s, input logic [9:0] a);
    if (s == 2'd1 && a == 10'h1A3) return 32'hDEAD_BEEF;
    return 32'hC000_0000 | (32'(s) << 16) | 32'(a);
  endfunction

  assign buf_data = (age == 4'(BUF_LAT - 1)) ? mem_word(buf_sel, buf_addr) : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one read with RREADY high; lat counts cycles from the AR handshake
  // to RVALID (-1 if it never came).
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output logic en_seen);
    int n;
    ax.araddr  = addr;
    ax.arvalid = 1'b1;
    ax.rready  = 1'b1;
    en_seen    = 1'b0;
    lat        = -1;
    data       = 'x;
    resp       = 'x;
    n = 0;
    while (!ax.arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    ax.arvalid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (buf_en) en_seen = 1'b1;
      if (ax.rvalid) begin
        lat  = c;
        data = ax.rdata;
        resp = ax.rresp;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    ax.araddr  = '0;
    ax.arvalid = 1'b0;
    ax.rready  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ax.arready, ax.rvalid, buf_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl arready/rvalid/buf_en got %b want 000", {ax.arready, ax.rvalid, buf_en});
    end
    checks++;
    if ({ax.rdata, ax.rresp, buf_addr, buf_sel} !== '0) begin
      errors++;
      $display("FAIL reset_data rdata %h rresp %b buf_addr %h buf_sel %0d want all zero",
               ax.rdata, ax.rresp, buf_addr, buf_sel);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ax.arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_arready_rise got %b want 1", ax.arready);
    end
  endtask

  task automatic test_reg_sr;
    sr_c       = 4'b0101;
    ax.araddr  = 32'h4;
    ax.arvalid = 1'b1;
    ax.rready  = 1'b0;
    tick();
    ax.arvalid = 1'b0;
    sr_c       = 4'b1010;
    checks++;
    if ({ax.rvalid, buf_en} !== 2'b10 || ax.rdata !== 32'h5 || ax.rresp !== 2'b00) begin
      errors++;
      $display("FAIL sr_read rvalid %b buf_en %b rdata %h rresp %b want 1 0 00000005 00",
               ax.rvalid, buf_en, ax.rdata, ax.rresp);
    end
    tick();
    checks++;
    if (ax.rvalid !== 1'b1 || ax.rdata !== 32'h5) begin
      errors++;
      $display("FAIL sr_hold rvalid %b rdata %h want 1 00000005", ax.rvalid, ax.rdata);
    end
    ax.rready = 1'b1;
    tick();
    ax.rready = 1'b0;
    checks++;
    if ({ax.rvalid, ax.arready} !== 2'b01) begin
      errors++;
      $display("FAIL sr_beat rvalid/arready got %b want 01", {ax.rvalid, ax.arready});
    end
  endtask

  task automatic test_buf_stall;
    logic hold_ok;
    ax.araddr  = 32'h0000_268C;  // region 2, word 0x1A3
    ax.arvalid = 1'b1;
    ax.rready  = 1'b0;
    tick();
    ax.arvalid = 1'b0;
    checks++;
    if (buf_en !== 1'b1 || buf_sel !== 2'd1 || buf_addr !== 10'h1A3 || ax.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL buf_strobe buf_en %b sel %0d addr %h rvalid %b want 1 1 1a3 0",
               buf_en, buf_sel, buf_addr, ax.rvalid);
    end
    tick();
    tick();
    checks++;
    if (buf_en !== 1'b0 || ax.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL buf_wait buf_en %b rvalid %b at T+3 want 0 0", buf_en, ax.rvalid);
    end
    tick();
    checks++;
    if (ax.rvalid !== 1'b1 || ax.rdata !== 32'hDEAD_BEEF || ax.rresp !== 2'b00) begin
      errors++;
      $display("FAIL buf_resp rvalid %b rdata %h rresp %b at T+4 want 1 deadbeef 00",
               ax.rvalid, ax.rdata, ax.rresp);
    end
    ax.araddr  = 32'h0;
    ax.arvalid = 1'b1;
    hold_ok    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ax.rvalid !== 1'b1 || ax.rdata !== 32'hDEAD_BEEF || ax.rresp !== 2'b00 ||
          ax.arready !== 1'b0 || buf_en !== 1'b0) hold_ok = 1'b0;
    end
    checks++;
    if (hold_ok !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold response changed or AR accepted: rvalid %b rdata %h rresp %b arready %b want 1 deadbeef 00 0",
               ax.rvalid, ax.rdata, ax.rresp, ax.arready);
    end
    ax.rready = 1'b1;
    tick();
    checks++;
    if ({ax.rvalid, ax.arready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_release rvalid/arready got %b want 01", {ax.rvalid, ax.arready});
    end
    tick();
    ax.arvalid = 1'b0;
    checks++;
    if (ax.rvalid !== 1'b1 || ax.rdata !== 32'h0 || ax.rresp !== 2'b00) begin
      errors++;
      $display("FAIL cr_read rvalid %b rdata %h rresp %b want 1 00000000 00", ax.rvalid, ax.rdata, ax.rresp);
    end
    tick();
    ax.rready = 1'b0;
  endtask

  task automatic test_buf_last;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        en;
    do_read(32'h0000_4FFF, d, r, lat, en);  // region 4, word 0x3FF, byte bits set
    checks++;
    if (lat !== 1 + BUF_LAT || d !== 32'hC003_03FF || r !== 2'b00 || en !== 1'b1) begin
      errors++;
      $display("FAIL buf_last lat %0d data %h resp %b en %b want 4 c00303ff 00 1", lat, d, r, en);
    end
    checks++;
    if (buf_sel !== 2'd3 || buf_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL buf_addr_hold sel %0d addr %h want 3 3ff", buf_sel, buf_addr);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        en;
    logic        seen;
    ax.araddr  = 32'h0000_268C;
    ax.arvalid = 1'b1;
    ax.rready  = 1'b1;
    tick();
    ax.arvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ax.arready, ax.rvalid, buf_en} !== 3'b000 || buf_addr !== 10'h0 || buf_sel !== 2'd0) begin
      errors++;
      $display("FAIL wait_reset arready/rvalid/buf_en %b addr %h sel %0d want 000 000 0",
               {ax.arready, ax.rvalid, buf_en}, buf_addr, buf_sel);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ax.rvalid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL wait_reset_drop rvalid seen %b want 0", seen);
    end
    sr_c = 4'b0011;
    do_read(32'h4, d, r, lat, en);
    checks++;
    if (lat !== 1 || d !== 32'h3 || r !== 2'b00 || en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_read lat %0d data %h resp %b en %b want 1 00000003 00 0", lat, d, r, en);
    end
  endtask

  task automatic test_slverr_errcnt;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        en;
    do_read(32'h0000_5000, d, r, lat, en);  // region NUM_BUF+1
    checks++;
    if (lat !== 1 || d !== 32'h0 || r !== 2'b10 || en !== 1'b0) begin
      errors++;
      $display("FAIL err_region lat %0d data %h resp %b en %b want 1 00000000 10 0", lat, d, r, en);
    end
    do_read(32'h0000_000C, d, r, lat, en);  // region 0, word 3
    checks++;
    if (lat !== 1 || d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("FAIL err_reg_word lat %0d data %h resp %b want 1 00000000 10", lat, d, r);
    end
    do_read(32'h0000_F000, d, r, lat, en);  // region 15
    checks++;
    if (lat !== 1 || r !== 2'b10 || en !== 1'b0) begin
      errors++;
      $display("FAIL err_region15 lat %0d resp %b en %b want 1 10 0", lat, r, en);
    end
    do_read(32'h0000_0008, d, r, lat, en);
`ifdef DATA_READ_AXI_ERRCNT_EN
    checks++;
    if (d !== 32'd3 || r !== 2'b00) begin
      errors++;
      $display("FAIL errcnt_first data %h resp %b want 00000003 00", d, r);
    end
`else
    checks++;
    if (d !== 32'd0 || r !== 2'b00) begin
      errors++;
      $display("FAIL errcnt_off data %h resp %b want 00000000 00", d, r);
    end
`endif
    do_read(32'h0000_0008, d, r, lat, en);
    checks++;
    if (d !== 32'd0 || r !== 2'b00) begin
      errors++;
      $display("FAIL errcnt_second data %h resp %b want 00000000 00", d, r);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        en;
    int          c0;
    c0 = cyc;
    sr_c = 4'b1001;
    do_read(32'h4, d, r, lat, en);
    do_read(32'h0, d, r, lat, en);
    do_read(32'h4, d, r, lat, en);
    checks++;
    if (cyc - c0 !== 6 || d !== 32'h9 || lat !== 1) begin
      errors++;
      $display("FAIL back_to_back cycles %0d data %h lat %0d want 6 00000009 1", cyc - c0, d, lat);
    end
    checks++;
    if (ax.arready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_arready got %b want 1", ax.arready);
    end
  endtask

  initial begin
    test_reset();
    test_reg_sr();
    test_buf_stall();
    test_buf_last();
    test_reset_in_wait();
    test_slverr_errcnt();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
